alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
Registered execute/writeback stage directly downstream of the combinational ALU. It selects the ALU output for the current opcode and computes and holds the N/Z/C/V flags, which the ALU itself does not produce. It presents results to the register-file write port over a valid/ready handshake; MUL produces two writeback beats, low half then high half.
It also drives the ALU carry input so ADC consumes the stored C flag.

Parameters:
W, 32, datapath width (must match ALU).
AW, 4, register address width; MUL high half targets (rd+1) mod 2^AW.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream has an operation
in_ready  out  1  stage can accept (combinational)
op  in  4  opcode (package enum)
rd  in  AW  destination register
flag_we  in  1  update flags with this op
x, y  in  W  ALU operands (for C/V)
summ, sub, mult_h, mult_l, zand, zor, zxor, znot, ashiftl, ashiftr, lshiftl, lshiftr, revers  in  W each  ALU results
ocarry  in  1  ALU add carry-out
alu_carry  out  1  ALU carry input: C flag when op==ADC, else 0 (combinational)
wb_valid  out  1  writeback beat valid
wb_ready  in  1  register file accepts
wb_addr  out  AW  writeback address
wb_data  out  W  writeback data
flags  out  4  {N,Z,C,V}, registered
illegal  out  1  one-cycle pulse: illegal op consumed

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. Reset clears all outputs to 0: state=EMPTY, wb_valid=0, wb_addr=0, wb_data=0, flags=0, illegal=0.
- Opcodes: ADD=0, ADC=1, SUB=2, MUL=3, AND=4, OR=5, XOR=6, NOT=7, ASL=8, ASR=9, LSL=10, LSR=11, REV=12. Codes 13-15 are illegal.
- Result mux: ADD and ADC select summ; SUB selects sub (x-y); NOT selects znot; the remaining ops select their matching ALU output.
- Accept condition: in_valid && in_ready. Latency is 1: wb_valid is asserted the cycle after accept.
- FSM states:
  - EMPTY: in_ready=1.
  - ONE: one beat held. This is a non-MUL result, or the MUL low half with hi_pending=1.
  - HI: MUL high half held.
- in_ready = EMPTY || (ONE && !hi_pending && wb_ready) || (HI && wb_ready). This allows back-to-back throughput of 1 op/cycle for non-MUL ops.
- FSM transitions:
  - Accept of a legal non-MUL op -> ONE, with wb_addr=rd and wb_data=result.
  - Accept of MUL -> ONE, with wb_data=mult_l, wb_addr=rd, hi_pending=1; the stage also latches mult_h.
  - ONE with hi_pending and wb_ready -> HI, with wb_data=mult_h and wb_addr=rd+1 (wraps modulo 2^AW).
  - Last beat accepted (wb_ready) with no new accept -> EMPTY. With a simultaneous accept -> ONE with the new op.
- Flags are updated only on accept with flag_we=1, and are visible the next cycle. Rules:
  - ADD/ADC: C=ocarry; V=(x[W-1]==y[W-1]) && (summ[W-1]!=x[W-1]).
  - SUB: C=(x>=y) unsigned (no-borrow convention); V=(x[W-1]!=y[W-1]) && (sub[W-1]!=x[W-1]).
  - MUL: N=mult_h[W-1]; Z=({mult_h,mult_l}==0); C and V unchanged.
  - Logic, shift, REV: N and Z from the result; C and V unchanged.
  - All other ops: N=result[W-1]; Z=(result==0).
- Illegal op: it is consumed when in_ready=1. There is no writeback and no flag change; illegal=1 for exactly the next cycle.
- Backpressure: while wb_valid && !wb_ready, wb_addr and wb_data are held stable. The ALU inputs are not captured.
- alu_carry uses flags registered before the current op. Two ADCs back-to-back see the C produced by the first, because flags update at accept.
- Reset asserted mid-MUL drops the pending high half; no beat is emitted after reset release.

Decomposition:
- Shared package cpu_alu_pkg holds the op enum values, OP_W=4, FLAG index constants N=3, Z=2, C=1, V=0, and W.
- One sub-module, alu_flag_calc, is combinational. It takes op, x, y, ALU results, ocarry and current flags, and returns next flags. The FSM and datapath registers stay in alu_wb_stage.

Test Plan:
- ADD x=2, y=6, flag_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=8, wb_addr=rd; flags={0,0,0,0}.
- C=1 set by the preceding op, then ADC x=2, y=6 -> alu_carry=1 during accept; wb_data=9 (summ driven by ALU with carry).
- ADD x=y=0xFFFFFFFF -> wb_data=0xFFFFFFFE; flags N=1, Z=0, C=1, V=0. Then SUB x=10, y=-20 -> wb_data=30; flags N=0, Z=0, C=0, V=0.
- MUL x=y=0x7FFFFFFF, rd=15, wb_ready=1 -> beat 1: addr=15, data=0x00000001; beat 2: addr=0, data=0x3FFFFFFF. in_ready=0 during beat 1; Z=0, N=0.
- wb_ready=0 for 3 cycles with a result held -> wb_data and wb_addr are stable and in_ready=0. On release, one beat only, with no duplicate.
- op=13 -> no wb_valid, flags unchanged, illegal pulses 1 cycle. rst_n low for 1 cycle during MUL beat 1 -> outputs zero immediately; no high-half beat after release.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the ALU execute/writeback slice: opcodes,
// flag bit positions, writeback FSM states and the datapath width.
package cpu_alu_pkg;

  localparam int W    = 32;
  localparam int OP_W = 4;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_ASL = 4'd8,
    OP_ASR = 4'd9,
    OP_LSL = 4'd10,
    OP_LSR = 4'd11,
    OP_REV = 4'd12
  } op_e;

  // EMPTY: nothing held; ONE: one beat held (maybe MUL low half);
  // HI: MUL high half held
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_HI    = 2'd2
  } wbState_e;

  // Codes above REV have no ALU result behind them
  function automatic logic isLegalOp(input logic [OP_W-1:0] code);
    return (code <= 4'(OP_REV));
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V generator. Given the current op, operands, ALU
// results and the flags currently held, returns the flags this op would
// leave behind. Ops that do not define C/V pass the old values through.
module alu_flag_calc #(
  parameter int W = cpu_alu_pkg::W
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] summ_i,
  input  logic [W-1:0] sub_i,
  input  logic [W-1:0] result_i,
  input  logic [W-1:0] multH_i,
  input  logic [W-1:0] multL_i,
  input  logic         ocarry_i,
  input  logic [3:0]   flags_i,
  output logic [3:0]   flags_o
);
  import cpu_alu_pkg::*;

  // Per-op flag rules; start from the held flags so C/V survive by default
  always_comb begin
    flags_o = flags_i;
    case (op_i)
      OP_ADD, OP_ADC: begin
        flags_o[FLAG_N] = summ_i[W-1];
        flags_o[FLAG_Z] = (summ_i == '0);
        flags_o[FLAG_C] = ocarry_i;
        flags_o[FLAG_V] = (x_i[W-1] == y_i[W-1]) && (summ_i[W-1] != x_i[W-1]);
      end
      OP_SUB: begin
        flags_o[FLAG_N] = sub_i[W-1];
        flags_o[FLAG_Z] = (sub_i == '0);
        flags_o[FLAG_C] = (x_i >= y_i);
        flags_o[FLAG_V] = (x_i[W-1] != y_i[W-1]) && (sub_i[W-1] != x_i[W-1]);
      end
      OP_MUL: begin
        flags_o[FLAG_N] = multH_i[W-1];
        flags_o[FLAG_Z] = ((multH_i | multL_i) == '0);
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_ASL, OP_ASR, OP_LSL, OP_LSR, OP_REV: begin
        flags_o[FLAG_N] = result_i[W-1];
        flags_o[FLAG_Z] = (result_i == '0);
      end
      default: begin
        flags_o = flags_i;
      end
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Registered execute/writeback stage behind the combinational ALU.
// Picks the ALU result for the accepted op, keeps the N/Z/C/V flags,
// and hands results to the register file over valid/ready. MUL takes
// two beats: low half to rd, then high half to rd+1.
module alu_wb_stage #(
  parameter int W  = cpu_alu_pkg::W,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] rd,
  input  logic          flag_we,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  summ,
  input  logic [W-1:0]  sub,
  input  logic [W-1:0]  mult_h,
  input  logic [W-1:0]  mult_l,
  input  logic [W-1:0]  zand,
  input  logic [W-1:0]  zor,
  input  logic [W-1:0]  zxor,
  input  logic [W-1:0]  znot,
  input  logic [W-1:0]  ashiftl,
  input  logic [W-1:0]  ashiftr,
  input  logic [W-1:0]  lshiftl,
  input  logic [W-1:0]  lshiftr,
  input  logic [W-1:0]  revers,
  input  logic          ocarry,
  output logic          alu_carry,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_addr,
  output logic [W-1:0]  wb_data,
  output logic [3:0]    flags,
  output logic          illegal
);
  import cpu_alu_pkg::*;

  wbState_e      state_q, state_d;
  logic          hiPending_q, hiPending_d;
  logic [W-1:0]  multHigh_q, multHigh_d;
  logic [AW-1:0] wbAddr_q, wbAddr_d;
  logic [W-1:0]  wbData_q, wbData_d;
  logic [3:0]    flags_q, flags_d;
  logic          illegal_q, illegal_d;

  logic [W-1:0]  result;
  logic [3:0]    nextFlags;
  logic          accept;
  logic          opLegal;
  logic          opIsMul;

  assign opLegal = isLegalOp(op);
  assign opIsMul = (op == OP_MUL);
  assign accept  = in_valid && in_ready;

  // ADC adds the C flag held before this op; every other op adds zero
  assign alu_carry = (op == OP_ADC) && flags_q[FLAG_C];

  assign wb_valid = (state_q != ST_EMPTY);
  assign wb_addr  = wbAddr_q;
  assign wb_data  = wbData_q;
  assign flags    = flags_q;
  assign illegal  = illegal_q;

  // Select the ALU output that belongs to the current opcode
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADC: result = summ;
      OP_SUB:         result = sub;
      OP_MUL:         result = mult_l;
      OP_AND:         result = zand;
      OP_OR:          result = zor;
      OP_XOR:         result = zxor;
      OP_NOT:         result = znot;
      OP_ASL:         result = ashiftl;
      OP_ASR:         result = ashiftr;
      OP_LSL:         result = lshiftl;
      OP_LSR:         result = lshiftr;
      OP_REV:         result = revers;
      default:        result = '0;
    endcase
  end

  alu_flag_calc #(
    .W(W)
  ) uFlagCalc (
    .op_i     (op),
    .x_i      (x),
    .y_i      (y),
    .summ_i   (summ),
    .sub_i    (sub),
    .result_i (result),
    .multH_i  (mult_h),
    .multL_i  (mult_l),
    .ocarry_i (ocarry),
    .flags_i  (flags_q),
    .flags_o  (nextFlags)
  );

  // Ready when empty, or when the only beat held is leaving this cycle
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_ONE:   in_ready = !hiPending_q && wb_ready;
      ST_HI:    in_ready = wb_ready;
      default:  in_ready = 1'b0;
    endcase
  end

  // Next state: a legal accept always loads a fresh beat, otherwise drain
  always_comb begin
    state_d     = state_q;
    hiPending_d = hiPending_q;
    multHigh_d  = multHigh_q;
    wbAddr_d    = wbAddr_q;
    wbData_d    = wbData_q;
    flags_d     = flags_q;
    illegal_d   = accept && !opLegal;

    if (accept && opLegal) begin
      state_d     = ST_ONE;
      wbAddr_d    = rd;
      hiPending_d = opIsMul;
      if (opIsMul) begin
        wbData_d   = mult_l;
        multHigh_d = mult_h;
      end else begin
        wbData_d = result;
      end
      if (flag_we) begin
        flags_d = nextFlags;
      end
    end else begin
      case (state_q)
        ST_ONE: begin
          if (wb_ready) begin
            if (hiPending_q) begin
              state_d     = ST_HI;
              wbAddr_d    = wbAddr_q + AW'(1);
              wbData_d    = multHigh_q;
              hiPending_d = 1'b0;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        ST_HI: begin
          if (wb_ready) begin
            state_d = ST_EMPTY;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops any pending MUL high half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      hiPending_q <= 1'b0;
      multHigh_q  <= '0;
      wbAddr_q    <= '0;
      wbData_q    <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hiPending_q <= hiPending_d;
      multHigh_q  <= multHigh_d;
      wbAddr_q    <= wbAddr_d;
      wbData_q    <= wbData_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized bench for alu_wb_stage. A behavioural model keeps the
// pending writeback beats in a queue and recomputes flags from plain
// signed/unsigned arithmetic; the ALU results are generated here too.
module tb_alu_wb_stage;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [AW-1:0] rd;
  logic          flag_we;
  logic [W-1:0]  x, y;
  logic [W-1:0]  summ, sub, mult_h, mult_l, zand, zor, zxor, znot;
  logic [W-1:0]  ashiftl, ashiftr, lshiftl, lshiftr, revers;
  logic          ocarry;
  logic          alu_carry;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [3:0]    flags;
  logic          illegal;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } beat_t;

  beat_t      beatQ[$];
  logic [3:0] flagsModel;
  logic       illegalModel;
  int         passCount;
  int         checkCount;

  alu_wb_stage #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .flag_we   (flag_we),
    .x         (x),
    .y         (y),
    .summ      (summ),
    .sub       (sub),
    .mult_h    (mult_h),
    .mult_l    (mult_l),
    .zand      (zand),
    .zor       (zor),
    .zxor      (zxor),
    .znot      (znot),
    .ashiftl   (ashiftl),
    .ashiftr   (ashiftr),
    .lshiftl   (lshiftl),
    .lshiftr   (lshiftr),
    .revers    (revers),
    .ocarry    (ocarry),
    .alu_carry (alu_carry),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flags     (flags),
    .illegal   (illegal)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the DUT disagrees
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Registered outputs must reflect the model after the last edge
  task automatic checkRegistered();
    checkOutput("wb_valid", 64'(wb_valid), 64'(beatQ.size() > 0));
    if (beatQ.size() > 0) begin
      checkOutput("wb_addr", 64'(wb_addr), 64'(beatQ[0].addr));
      checkOutput("wb_data", 64'(wb_data), 64'(beatQ[0].data));
    end
    checkOutput("flags", 64'(flags), 64'(flagsModel));
    checkOutput("illegal", 64'(illegal), 64'(illegalModel));
  endtask

  // One cycle: check held outputs, drive ALU inputs, check handshake and
  // carry, then advance the model as the clock edge would
  task automatic applyStimulus(input logic inValid, input logic [3:0] opIn,
                               input logic [AW-1:0] rdIn, input logic flagWe,
                               input logic [W-1:0] xIn, input logic [W-1:0] yIn,
                               input logic wbReady);
    logic          cin;
    logic [W:0]    sum33;
    logic [63:0]   prod;
    logic [W-1:0]  res;
    logic          expReady;
    longint        sx, sy, total;
    beat_t         b;

    checkRegistered();

    cin   = (opIn == 4'd1) ? flagsModel[1] : 1'b0;
    sum33 = {1'b0, xIn} + {1'b0, yIn} + {{W{1'b0}}, cin};
    prod  = {32'b0, xIn} * {32'b0, yIn};

    in_valid = inValid;
    op       = opIn;
    rd       = rdIn;
    flag_we  = flagWe;
    wb_ready = wbReady;
    x        = xIn;
    y        = yIn;
    summ     = sum33[W-1:0];
    ocarry   = sum33[W];
    sub      = xIn - yIn;
    mult_h   = prod[63:32];
    mult_l   = prod[31:0];
    zand     = xIn & yIn;
    zor      = xIn | yIn;
    zxor     = xIn ^ yIn;
    znot     = ~xIn;
    ashiftl  = xIn <<< yIn[4:0];
    ashiftr  = W'($signed(xIn) >>> yIn[4:0]);
    lshiftl  = xIn << yIn[4:0];
    lshiftr  = xIn >> yIn[4:0];
    for (int i = 0; i < W; i++) revers[i] = xIn[W-1-i];
    #1;

    expReady = (beatQ.size() == 0) || (beatQ.size() == 1 && wbReady);
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    checkOutput("alu_carry", 64'(alu_carry), 64'(cin));

    if (beatQ.size() > 0 && wbReady) beatQ.delete(0);
    illegalModel = 1'b0;
    if (inValid && expReady) begin
      if (opIn > 4'd12) begin
        illegalModel = 1'b1;
      end else begin
        case (opIn)
          4'd0, 4'd1: res = summ;
          4'd2:       res = sub;
          4'd3:       res = mult_l;
          4'd4:       res = zand;
          4'd5:       res = zor;
          4'd6:       res = zxor;
          4'd7:       res = znot;
          4'd8:       res = ashiftl;
          4'd9:       res = ashiftr;
          4'd10:      res = lshiftl;
          4'd11:      res = lshiftr;
          default:    res = revers;
        endcase
        b.addr = rdIn;
        b.data = res;
        beatQ.push_back(b);
        if (opIn == 4'd3) begin
          b.addr = rdIn + AW'(1);
          b.data = mult_h;
          beatQ.push_back(b);
        end
        if (flagWe) begin
          sx = $signed(xIn);
          sy = $signed(yIn);
          if (opIn <= 4'd1) begin
            total = sx + sy + longint'(cin);
            flagsModel = {res[W-1], res == 0, sum33[W],
                          (total > 64'sd2147483647) || (total < -64'sd2147483648)};
          end else if (opIn == 4'd2) begin
            total = sx - sy;
            flagsModel = {res[W-1], res == 0, xIn >= yIn,
                          (total > 64'sd2147483647) || (total < -64'sd2147483648)};
          end else if (opIn == 4'd3) begin
            flagsModel = {prod[63], prod == 64'd0, flagsModel[1:0]};
          end else begin
            flagsModel = {res[W-1], res == 0, flagsModel[1:0]};
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Pull reset low between edges; everything must clear at once
  task automatic applyReset();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("rst wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst wb_addr", 64'(wb_addr), 64'd0);
    checkOutput("rst wb_data", 64'(wb_data), 64'd0);
    checkOutput("rst flags", 64'(flags), 64'd0);
    checkOutput("rst illegal", 64'(illegal), 64'd0);
    beatQ.delete();
    flagsModel   = 4'd0;
    illegalModel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Directed scenarios first, then a long randomized run
  initial begin
    logic [W-1:0] heldData;
    logic [AW-1:0] heldAddr;
    logic [W-1:0] pool [5];

    passCount = 0;
    checkCount = 0;
    op = 4'd0; rd = '0; flag_we = 1'b0; x = '0; y = '0;
    summ = '0; sub = '0; mult_h = '0; mult_l = '0; zand = '0; zor = '0;
    zxor = '0; znot = '0; ashiftl = '0; ashiftr = '0; lshiftl = '0;
    lshiftr = '0; revers = '0; ocarry = 1'b0;
    pool[0] = 32'h0; pool[1] = 32'hFFFFFFFF; pool[2] = 32'h7FFFFFFF;
    pool[3] = 32'h80000000; pool[4] = 32'h1;
    @(negedge clk);
    applyReset();

    // ADD 2+6
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b1, 32'd2, 32'd6, 1'b1);
    checkOutput("add data", 64'(wb_data), 64'd8);
    checkOutput("add addr", 64'(wb_addr), 64'd3);
    checkOutput("add flags", 64'(flags), 64'd0);

    // ADD of all ones sets N and C, then ADC picks the carry up
    applyStimulus(1'b1, 4'd0, 4'd4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    checkOutput("addmax data", 64'(wb_data), 64'hFFFFFFFE);
    checkOutput("addmax flags", 64'(flags), 64'b1010);
    applyStimulus(1'b1, 4'd1, 4'd5, 1'b1, 32'd2, 32'd6, 1'b1);
    checkOutput("adc data", 64'(wb_data), 64'd9);

    // SUB 10 - (-20)
    applyStimulus(1'b1, 4'd2, 4'd6, 1'b1, 32'd10, 32'hFFFFFFEC, 1'b1);
    checkOutput("sub data", 64'(wb_data), 64'd30);
    checkOutput("sub flags", 64'(flags), 64'd0);

    // MUL with address wrap on the high half
    applyStimulus(1'b1, 4'd3, 4'd15, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    checkOutput("mul lo addr", 64'(wb_addr), 64'd15);
    checkOutput("mul lo data", 64'(wb_data), 64'h1);
    checkOutput("mul lo in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("mul hi addr", 64'(wb_addr), 64'd0);
    checkOutput("mul hi data", 64'(wb_data), 64'h3FFFFFFF);
    checkOutput("mul flags", 64'(flags), 64'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);

    // Backpressure for three cycles with a new op waiting upstream
    applyStimulus(1'b1, 4'd6, 4'd9, 1'b0, 32'h1234, 32'h00FF, 1'b1);
    heldData = wb_data;
    heldAddr = wb_addr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd5, 4'd2, 1'b0, 32'hAAAA, 32'h5555, 1'b0);
      checkOutput("bp data", 64'(wb_data), 64'(heldData));
      checkOutput("bp addr", 64'(wb_addr), 64'(heldAddr));
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("bp no dup", 64'(wb_valid), 64'd0);

    // Illegal op
    applyStimulus(1'b1, 4'd13, 4'd1, 1'b1, 32'd0, 32'd0, 1'b1);
    checkOutput("illegal pulse", 64'(illegal), 64'd1);
    checkOutput("illegal no wb", 64'(wb_valid), 64'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("illegal one cycle", 64'(illegal), 64'd0);

    // Reset while the MUL low half is held
    applyStimulus(1'b1, 4'd3, 4'd7, 1'b1, 32'h12345, 32'h6789A, 1'b0);
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("no beat after reset", 64'(wb_valid), 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rx, ry;
      rx = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
      ry = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    AW'($urandom), 1'($urandom), rx, ry,
                    $urandom_range(0, 3) != 0);
    end
    checkRegistered();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
